// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle between the ALU controller, the execute
// unit and the writeback/branch consumer.
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             neg_flag;
  logic             illegal_op;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero_flag, carry_flag, neg_flag, illegal_op
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero_flag, carry_flag, neg_flag, illegal_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/ADD/SUB/CMP, bit-serial SLL/SRL, and a
// registered result/flags stage behind a valid/ready handshake.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_unit_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_left;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;
  logic             r_illegal;

  logic             w_accept;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_simple_res;
  logic             w_simple_carry;
  logic             w_simple_illegal;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_out;

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_is_shift = (bus.alu_ctrl == 3'b100) || (bus.alu_ctrl == 3'b101);
  assign w_amt      = bus.op_b[SHW-1:0];
  assign w_sum      = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  // The top bit of the widened difference is the unsigned borrow.
  assign w_diff     = {1'b0, bus.op_a} - {1'b0, bus.op_b};

  always_comb begin
    w_simple_res     = '0;
    w_simple_carry   = 1'b0;
    w_simple_illegal = 1'b0;
    case (bus.alu_ctrl)
      3'b000: w_simple_res = bus.op_a & bus.op_b;
      3'b001: begin
        w_simple_res   = w_sum[WIDTH-1:0];
        w_simple_carry = w_sum[WIDTH];
      end
      3'b010, 3'b011: begin
        w_simple_res   = w_diff[WIDTH-1:0];
        w_simple_carry = w_diff[WIDTH];
      end
      3'b100, 3'b101: w_simple_res = bus.op_a;
      default: w_simple_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_step_val = r_work >> 1;
    w_step_out = r_work[0];
    if (r_left) begin
      w_step_val = r_work << 1;
      w_step_out = r_work[WIDTH-1];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (w_is_shift && (w_amt != '0)) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_ONE) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The working register keeps partial shifts away from the visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_illegal <= w_simple_illegal;
        if (w_is_shift && (w_amt != '0)) begin
          r_work <= bus.op_a;
          r_cnt  <= w_amt;
          r_left <= ~bus.alu_ctrl[0];
        end else begin
          r_result <= w_simple_res;
          r_carry  <= w_simple_carry;
          r_zero   <= (w_simple_res == '0);
          r_neg    <= w_simple_res[WIDTH-1];
        end
      end else if (r_state == S_SHIFT) begin
        r_work <= w_step_val;
        r_cnt  <= r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          r_result <= w_step_val;
          r_carry  <= w_step_out;
          r_zero   <= (w_step_val == '0);
          r_neg    <= w_step_val[WIDTH-1];
        end
      end
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.result     = r_result;
  assign bus.zero_flag  = r_zero;
  assign bus.carry_flag = r_carry;
  assign bus.neg_flag   = r_neg;
  assign bus.illegal_op = r_illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus random checks of alu_exec_unit against an arithmetic
// reference model of the execute-stage operations.
module tb_alu_exec_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         ill;
    int           lat;
  } exp_t;

  function automatic exp_t model(input logic [2:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned s;
    int          sh;
    e.res = '0;
    e.c   = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    sh    = int'(b) % W;
    case (ctrl)
      3'd0: e.res = a & b;
      3'd1: begin
        s     = int'(a) + int'(b);
        e.res = W'(s);
        e.c   = (s >= (1 << W));
      end
      3'd2, 3'd3: begin
        e.res = a - b;
        e.c   = (a < b);
      end
      3'd4: begin
        e.res = a << sh;
        e.c   = (sh > 0) ? a[W-sh] : 1'b0;
        e.lat = sh + 1;
      end
      3'd5: begin
        e.res = a >> sh;
        e.c   = (sh > 0) ? a[sh-1] : 1'b0;
        e.lat = sh + 1;
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int   lat;
    e = model(ctrl, a, b);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = ctrl;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 3'($urandom);
    bus.op_a     = W'($urandom);
    bus.op_b     = W'($urandom);
    @(negedge clk);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(e.lat));
    check("result", 32'(bus.result), 32'(e.res));
    check("carry", 32'(bus.carry_flag), 32'(e.c));
    check("zero", 32'(bus.zero_flag), 32'(e.z));
    check("neg", 32'(bus.neg_flag), 32'(e.n));
    check("illegal", 32'(bus.illegal_op), 32'(e.ill));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.alu_ctrl = 3'($urandom);
      bus.op_a     = W'($urandom);
      bus.op_b     = W'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", 32'(bus.result), 32'(e.res));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_xfer_valid", 32'(bus.out_valid), 32'd0);
    check("post_xfer_ready", 32'(bus.in_ready), 32'd1);
    $display("op ctrl=%0d a=0x%04h b=0x%04h -> result=0x%04h c=%0b z=%0b n=%0b ill=%0b lat=%0d",
             ctrl, a, b, e.res, e.c, e.z, e.n, e.ill, lat);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", {28'd0, bus.zero_flag, bus.carry_flag, bus.neg_flag, bus.illegal_op}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b001, 16'hFFFF, 16'h0001, 0);
    do_op(3'b010, 16'h0003, 16'h0005, 0);
    do_op(3'b011, 16'h1234, 16'h1234, 0);
    do_op(3'b100, 16'h8001, 16'h0013, 0);
    do_op(3'b101, 16'h0005, 16'h0001, 0);
    do_op(3'b000, 16'hF0F0, 16'h0FF0, 10);

    // Reset lands in the second shift cycle of an SRL by 15.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 3'b101;
    bus.op_a     = 16'hBEEF;
    bus.op_b     = 16'h000F;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midshift_rst_valid", 32'(bus.out_valid), 32'd0);
    check("midshift_rst_result", 32'(bus.result), 32'd0);
    check("midshift_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_stale_output", 32'(bus.out_valid), 32'd0);
    do_op(3'b000, 16'h00FF, 16'h0F0F, 0);

    do_op(3'b111, 16'h1234, 16'h5678, 0);
    do_op(3'b001, 16'h0002, 16'h0002, 0);
    do_op(3'b100, 16'hABCD, 16'h0010, 0);
    do_op(3'b100, 16'h1234, 16'h000F, 0);

    for (int k = 0; k < 40; k++) begin
      do_op(3'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. It sits directly downstream of the ALU controller and consumes its 3-bit ALU control code plus two register/immediate operands.
- AND, ADD, SUB and CMP complete in one cycle.
- SLL and SRL run iteratively, one bit per cycle, under a small FSM.
- Results and flags are held in an output register behind a valid/ready handshake toward writeback/branch logic.

Parameters:
- WIDTH, 16, operand and result width in bits; power of two, ≥4.
- SHW (local, derived), $clog2(WIDTH), shift-amount field width taken from op_b.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request; equals (state==IDLE).
- alu_ctrl  input  3  000 AND, 001 ADD, 010 SUB, 011 CMP, 100 SLL, 101 SRL, 110/111 illegal.
- op_a  input  WIDTH  first operand; the value shifted for SLL/SRL.
- op_b  input  WIDTH  second operand; for shifts only op_b[SHW-1:0] is used (shift amount).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero_flag  output  1  result == 0.
- carry_flag  output  1  carry/borrow/shifted-out bit.
- neg_flag  output  1  result[WIDTH-1].
- illegal_op  output  1  accepted code was 110/111.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; result, all flags, out_valid and the internal shift counter go to 0.
  - in_ready=1 while in IDLE, including during reset.
  - Reset mid-shift or mid-hold discards the operation; no partial result is ever presented.
- Handshake:
  - Accept when in_valid && in_ready at a clock edge.
  - Inputs are sampled only at acceptance; later input changes are ignored.
  - Result transfers when out_valid && out_ready.
  - The unit is single-entry: no new acceptance while busy or holding a result.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, simple op (AND/ADD/SUB/CMP/illegal) accepted: compute and register result and flags, go to DONE. out_valid=1 the cycle after acceptance (latency 1).
  - IDLE, SLL/SRL accepted with amount n=0: result=op_a, carry=0, go to DONE (latency 1).
  - IDLE, SLL/SRL accepted with n>0: load op_a into the working register, counter=n, carry=0, go to SHIFT.
  - SHIFT, each cycle: shift one bit (SLL: left, zero fill; SRL: logical right, zero fill), carry=bit shifted out, counter−1. The cycle the counter goes 1→0 transitions to DONE. out_valid asserts n+1 cycles after acceptance; maximum latency is WIDTH cycles (n=WIDTH−1).
  - DONE: out_valid=1; result and flags held stable while out_ready=0 (back-pressure is unlimited). On transfer: out_valid=0, return to IDLE. A new request can be accepted no earlier than the cycle after transfer.
- Arithmetic (all unsigned, results modulo 2^WIDTH):
  - ADD: result=a+b, carry=carry-out of bit WIDTH−1.
  - SUB and CMP: result=a−b, carry=borrow=(a<b).
    - CMP differs from SUB only downstream (no writeback); for CMP, zero_flag is the equality indication used by BEQ.
  - AND: result=a&b, carry=0.
  - Illegal code: result=0, carry=0, zero_flag=1, illegal_op=1. illegal_op is 0 for all legal codes and is cleared when the next operation is accepted.
- Flags are computed from the final registered result: zero=(result==0), neg=result[WIDTH−1]. Flags change only when a result is completed.
- Outputs change only on clock edges or on asynchronous reset; no combinational path from inputs to result or flags.

Test Plan:
- Reset then ADD 0xFFFF+0x0001 (WIDTH=16) -> in_ready=1 after reset; out_valid 1 cycle after accept; result=0x0000, zero=1, carry=1, neg=0.
- SUB 0x0003−0x0005, then CMP 0x1234 vs 0x1234 -> SUB: result=0xFFFE, carry=1, neg=1. CMP: result=0, zero=1, carry=0.
- SLL 0x8001 by op_b=0x0013 (n=3) -> in_ready=0 for 4 cycles; out_valid 4 cycles after accept; result=0x0008, carry=0 (last bit out). SRL 0x0005 by 1 -> result=0x0002, carry=1, latency 2.
- Hold out_ready=0 for 10 cycles after an AND 0xF0F0&0x0FF0 while toggling in_valid/op inputs -> result stays 0x00F0, in_ready stays 0, no new accept; transfer on out_ready=1 and IDLE next cycle.
- Assert rst_n low during cycle 2 of an SRL by 15 -> out_valid=0 and result=0 immediately; after release, ANDI-class AND 0x00FF&0x0F0F returns 0x000F with no stale shift output.
- alu_ctrl=3'b111 -> result=0, zero=1, illegal_op=1; the following ADD 2+2 gives result=4, illegal_op=0; SLL with n=0 on 0xABCD returns 0xABCD, carry=0, latency 1.
